// File: rtl/regfile_multiport.sv
// regfile_multiport: architectural register file for the pipelined Y86-64 core.
//
// Two combinational read ports (srca/srcb) with same-cycle bypass of the
// writes that will land at the next edge, two write ports (E from execute,
// M from memory, M wins on a shared destination) and a dump engine that
// streams every stored register out, one per cycle, for debug checking.
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   srca, srcb          read register IDs
//   vala, valb          read data (combinational, bypassed)
//   wr_en               global write enable (0 = bubble/stall)
//   dste, vale          E-port destination ID and data
//   dstm, valm          M-port destination ID and data
//   dump_req            start a full-file dump (ignored while one is running)
//   dump_busy           dump in progress
//   dump_valid          dump_idx/dump_data valid this cycle
//   dump_idx            index being dumped
//   dump_data           stored (unbypassed) contents of reg[dump_idx], else 0
module regfile_multiport #(
  parameter int                  DATA_W   = 64,
  parameter int                  NREG     = 15,
  parameter int                  ADDR_W   = 4,
  parameter logic [ADDR_W-1:0]   RNONE    = 4'hF,
  parameter logic [ADDR_W-1:0]   RSP_IDX  = 4'd4,
  parameter logic [DATA_W-1:0]   RSP_INIT = 64'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] srca,
  input  logic [ADDR_W-1:0] srcb,
  output logic [DATA_W-1:0] vala,
  output logic [DATA_W-1:0] valb,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] dste,
  input  logic [DATA_W-1:0] vale,
  input  logic [ADDR_W-1:0] dstm,
  input  logic [DATA_W-1:0] valm,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] regs_r [NREG];
  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_s;
  logic              we_e_s;
  logic              we_m_s;

  // An ID addresses storage only if it is not RNONE and is inside the file.
  function automatic logic id_ok(input logic [ADDR_W-1:0] id);
    return (id != RNONE) && (int'(id) < NREG);
  endfunction

  // Read priority: invalid ID -> 0, then M bypass, then E bypass, then storage.
  // M is checked first so the bypass matches what the M-over-E write stores.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] stored
  );
    if (!id_ok(src)) begin
      return '0;
    end else if (wr_en && (src == dstm)) begin
      return valm;
    end else if (wr_en && (src == dste)) begin
      return vale;
    end else begin
      return stored;
    end
  endfunction

  assign we_e_s = wr_en && id_ok(dste);
  assign we_m_s = wr_en && id_ok(dstm);

  // Register storage: reset image, then E write followed by M write so M wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= (i == int'(RSP_IDX)) ? RSP_INIT : DATA_W'(i);
      end
    end else begin
      if (we_e_s) begin
        regs_r[dste] <= vale;
      end
      if (we_m_s) begin
        regs_r[dstm] <= valm;
      end
    end
  end

  // Combinational read ports; stored value is only indexed when the ID is valid.
  always_comb begin
    vala = '0;
    valb = '0;
    vala = read_port(srca, id_ok(srca) ? regs_r[srca] : '0);
    valb = read_port(srcb, id_ok(srcb) ? regs_r[srcb] : '0);
  end

  // Dump FSM state and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Dump FSM next state: a request is honoured only from IDLE, so a held
  // request leaves one IDLE cycle between consecutive scans.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (dump_req) begin
          state_s = SCAN;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == LAST_IDX) begin
          state_s = IDLE;
          idx_s   = '0;
        end else begin
          idx_s = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // Dump outputs: stored contents only (no bypass), zero when not scanning.
  always_comb begin
    dump_busy  = (state_r == SCAN);
    dump_valid = (state_r == SCAN);
    dump_idx   = idx_r;
    if (state_r == SCAN) begin
      dump_data = regs_r[idx_r];
    end else begin
      dump_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  localparam int NREG = 15;

  logic        clk;
  logic        rst_n;
  logic [3:0]  srca, srcb, dste, dstm;
  logic [63:0] vala, valb, vale, valm, dump_data;
  logic        wr_en, dump_req, dump_busy, dump_valid;
  logic [3:0]  dump_idx;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Reference model: register contents plus a beat counter for the dump.
  logic [63:0] m [NREG];
  int          m_left = 0;
  int          m_idx  = 0;

  regfile_multiport dut (
    .clk(clk), .rst_n(rst_n), .srca(srca), .srcb(srcb), .vala(vala), .valb(valb),
    .wr_en(wr_en), .dste(dste), .vale(vale), .dstm(dstm), .valm(valm),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_read(input logic [3:0] src);
    if (src >= NREG) return 64'd0;
    if (wr_en && src == dstm) return valm;
    if (wr_en && src == dste) return vale;
    return m[src];
  endfunction

  // Model update: same rules as the architectural description.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) m[i] = (i == 4) ? 64'd4 : 64'(i);
      m_left = 0;
      m_idx  = 0;
    end else begin
      if (wr_en) begin
        if (dste < NREG) m[dste] = vale;
        if (dstm < NREG) m[dstm] = valm;
      end
      if (m_left > 0) begin
        m_left = m_left - 1;
        m_idx  = m_idx + 1;
      end else if (dump_req) begin
        m_left = NREG;
        m_idx  = 0;
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("vala", vala, exp_read(srca));
      chk("valb", valb, exp_read(srcb));
      chk("dump_busy", {63'd0, dump_busy}, {63'd0, m_left > 0});
      chk("dump_valid", {63'd0, dump_valid}, {63'd0, m_left > 0});
      if (m_left > 0) begin
        chk("dump_idx", {60'd0, dump_idx}, 64'(m_idx));
        chk("dump_data", dump_data, m[m_idx]);
      end else begin
        chk("dump_data_idle", dump_data, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; dump_req = 1'b0;
    srca = 4'd0; srcb = 4'd4; dste = 4'hF; dstm = 4'hF; vale = 64'd0; valm = 64'd0;
    #2 rst_n = 1'b0;
    step(); step();
    check_en = 1'b1;
    chk("rst_vala", vala, 64'd0);
    chk("rst_valb", valb, 64'd4);
    chk("rst_busy", {63'd0, dump_busy}, 64'd0);
    chk("rst_idx", {60'd0, dump_idx}, 64'd0);
    rst_n = 1'b1;

    // Full dump after reset.
    dump_req = 1'b1; step(); dump_req = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      chk("dump0_idx", {60'd0, dump_idx}, 64'(i));
      chk("dump0_data", dump_data, 64'(i));
      step();
    end
    chk("dump0_done", {63'd0, dump_busy}, 64'd0);

    // Same-cycle bypass, then stored value.
    wr_en = 1'b1; dste = 4'd2; vale = 64'hAA; dstm = 4'hF; srca = 4'd2; #1;
    chk("bypass_e", vala, 64'hAA);
    step(); wr_en = 1'b0; #1;
    chk("stored_e", vala, 64'hAA);

    // popq conflict: M wins.
    wr_en = 1'b1; dste = 4'd4; vale = 64'h100; dstm = 4'd4; valm = 64'h55; srca = 4'd4; #1;
    chk("popq_bypass", vala, 64'h55);
    step(); wr_en = 1'b0; dste = 4'hF; dstm = 4'hF; #1;
    chk("popq_stored", vala, 64'h55);

    // No write and no bypass with wr_en low; RNONE reads 0.
    dste = 4'd3; vale = 64'hFF; srca = 4'd3; srcb = 4'hF; #1;
    chk("nowr_bypass", vala, 64'd3);
    chk("rnone_read", valb, 64'd0);
    step(); #1;
    chk("nowr_stored", vala, 64'd3);
    dste = 4'hF;

    // Write during dump at the edge moving idx 5 -> 6.
    dump_req = 1'b1; step(); dump_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("scan_at5", {60'd0, dump_idx}, 64'd5);
    wr_en = 1'b1; dste = 4'd10; vale = 64'h1234; dstm = 4'hF;
    step(); wr_en = 1'b0; dste = 4'hF;
    for (int i = 0; i < 4; i++) step();
    chk("scan_idx10", {60'd0, dump_idx}, 64'd10);
    chk("scan_data10", dump_data, 64'h1234);
    for (int i = 0; i < 6; i++) step();
    chk("scan1_done", {63'd0, dump_busy}, 64'd0);

    // Async reset in the middle of a scan at idx 7.
    dump_req = 1'b1; step(); dump_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("scan_at7", {60'd0, dump_idx}, 64'd7);
    #1 rst_n = 1'b0; #1;
    chk("abort_busy", {63'd0, dump_busy}, 64'd0);
    chk("abort_valid", {63'd0, dump_valid}, 64'd0);
    chk("abort_data", dump_data, 64'd0);
    srca = 4'd4; srcb = 4'd10; #1;
    chk("abort_r4", vala, 64'd4);
    chk("abort_r10", valb, 64'd10);
    step(); rst_n = 1'b1;

    // Randomized traffic, including held dump requests.
    for (int c = 0; c < 2000; c++) begin
      srca     = 4'($urandom_range(0, 15));
      srcb     = 4'($urandom_range(0, 15));
      dste     = 4'($urandom_range(0, 15));
      dstm     = ($urandom_range(0, 3) == 0) ? dste : 4'($urandom_range(0, 15));
      vale     = {$urandom(), $urandom()};
      valm     = {$urandom(), $urandom()};
      wr_en    = 1'($urandom_range(0, 1));
      dump_req = (c >= 1000 && c < 1100) ? 1'b1 : ($urandom_range(0, 7) == 0);
      step();
    end
    wr_en = 1'b0; dump_req = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("final_idle", {63'd0, dump_busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
